serial_subtractor_64: RTL



---
 rtl/adder_pkg.sv | 17 +
 rtl/sub_digit.sv | 19 +
 rtl/serial_subtractor_64.sv | 115 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor family: default width,
// control state encoding and the digit-count helper.
package adder_pkg;

   localparam int WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-wide subtract slice: d = a - b - borrow_in, with borrow_out.
// Done as a + ~b + ~borrow_in so the carry out is the inverted borrow.
module sub_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_borrow,
   output logic [DIGIT-1:0] o_d,
   output logic             o_borrow
);

   logic [DIGIT:0] w_sum;

   assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{DIGIT{1'b0}}, ~i_borrow};
   assign o_d      = w_sum[DIGIT-1:0];
   assign o_borrow = ~w_sum[DIGIT];

endmodule

// File: rtl/serial_subtractor_64.sv
// Digit-serial unsigned subtractor: diff = in1 - in2 - bin over NDIG cycles,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor_64
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int NDIG  = ndig(WIDTH, DIGIT);
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_subtractor_64: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_diff;
   logic [WIDTH-1:0]   w_diff_next;
   logic               r_borrow;
   logic               r_bout;
   logic [CNT_W-1:0]   r_cnt;
   logic [DIGIT-1:0]   w_d;
   logic               w_borrow_out;
   logic               w_accept;
   logic               w_last;

   sub_digit #(.DIGIT(DIGIT)) u_digit (
      .i_a      (r_a[DIGIT-1:0]),
      .i_b      (r_b[DIGIT-1:0]),
      .i_borrow (r_borrow),
      .o_d      (w_d),
      .o_borrow (w_borrow_out)
   );

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

   // Only the slot selected by the counter takes the new digit; the rest hold.
   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_slot
         assign w_diff_next[gi*DIGIT +: DIGIT] =
            (r_cnt == CNT_W'(gi)) ? w_d : r_diff[gi*DIGIT +: DIGIT];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_a      <= in1;
            r_b      <= in2;
            r_borrow <= bin;
            r_cnt    <= '0;
         end else if (r_state == BUSY) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_borrow <= w_borrow_out;
            r_cnt    <= r_cnt + 1'b1;
            r_diff   <= w_diff_next;
            if (w_last) r_bout <= w_borrow_out;
         end
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;

endmodule
